// File: rtl/ysyx_25070198_simplebus_sram_pkg.sv
// Shared types and widths for the SimpleBus SRAM responder.
// Contents: FSM state enum, bus field widths, latency counter width.
// Optional feature macro used elsewhere: SIMPLEBUS_SRAM_RAND_DELAY_EN.
package ysyx_25070198_simplebus_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_MASK_W = 4;
    // Wide enough for LATENCY up to 15 plus up to 7 random extra cycles.
    localparam int LAT_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } sram_state_t;

endpackage

// File: rtl/ysyx_25070198_simplebus_sram_if.sv
// SimpleBus request/response bundle between the LSU (master) and a responder.
// Signals: reqValid/addr/wen/wdata/wmask from master; rdata/respValid from slave.
interface ysyx_25070198_simplebus_sram_if;
    import ysyx_25070198_simplebus_pkg::*;

    logic                 reqValid;
    logic [SB_ADDR_W-1:0] addr;
    logic                 wen;
    logic [SB_DATA_W-1:0] wdata;
    logic [SB_MASK_W-1:0] wmask;
    logic [SB_DATA_W-1:0] rdata;
    logic                 respValid;

    modport master (
        output reqValid, addr, wen, wdata, wmask,
        input  rdata, respValid
    );

    modport slave (
        input  reqValid, addr, wen, wdata, wmask,
        output rdata, respValid
    );

endinterface

// File: rtl/ysyx_25070198_simplebus_sram_lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR (taps 8,6,5,4), seeded to 8'hA5 on reset.
// Ports: clk, rst (sync, active-high), out[7:0] current LFSR state.
// Only compiled when SIMPLEBUS_SRAM_RAND_DELAY_EN is defined.
`ifdef SIMPLEBUS_SRAM_RAND_DELAY_EN
module ysyx_25070198_lfsr8 (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] out
);

    logic [7:0] lfsr_q;
    logic       fb;

    assign fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign out = lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], fb};
        end
    end

endmodule
`endif

// File: rtl/ysyx_25070198_simplebus_sram.sv
// SimpleBus responder: word-addressed SRAM with programmable response latency.
// Ports: clk, rst (sync, active-high), bus (slave modport of the SimpleBus if).
// Parameters: DEPTH words (power of two), LATENCY 1..15, AW derived.
// Macro SIMPLEBUS_SRAM_RAND_DELAY_EN adds 0..7 LFSR-driven extra cycles per request.
module ysyx_25070198_simplebus_sram
    import ysyx_25070198_simplebus_pkg::*;
#(
    parameter int  DEPTH   = 1024,
    parameter int  LATENCY = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    ysyx_25070198_simplebus_sram_if.slave bus
);

    sram_state_t          state, state_nx;
    logic [LAT_CNT_W-1:0] cnt, cnt_nx;
    logic [LAT_CNT_W-1:0] lat_total;

    logic [AW-1:0]        idx_q, idx_nx;
    logic                 wen_q, wen_nx;
    logic [SB_DATA_W-1:0] wdata_q;
    logic [SB_MASK_W-1:0] wmask_q;

    logic                 resp_valid_q;
    logic [SB_DATA_W-1:0] rdata_q, rdata_nx;
    logic                 accept;

    logic [SB_DATA_W-1:0] mem [DEPTH];

    // Address bits outside the word index are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^{bus.addr[SB_ADDR_W-1:AW+2], bus.addr[1:0]};

`ifdef SIMPLEBUS_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr_out;
    logic       unused_lfsr;

    ysyx_25070198_lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr_out)
    );

    assign unused_lfsr = ^lfsr_out[7:3];
    assign lat_total   = LAT_CNT_W'(LATENCY) + LAT_CNT_W'(lfsr_out[2:0]);
`else
    assign lat_total   = LAT_CNT_W'(LATENCY);
`endif

    assign accept = (state == IDLE) && bus.reqValid;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.reqValid) begin
                    if (lat_total == LAT_CNT_W'(1)) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = BUSY;
                        cnt_nx   = lat_total - LAT_CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                cnt_nx = cnt - LAT_CNT_W'(1);
                if (cnt == LAT_CNT_W'(1)) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read data is fetched on the edge entering RESP so that the output is a
    // register; on a direct IDLE->RESP hop the index comes straight off the bus.
    always_comb begin
        idx_nx   = accept ? bus.addr[AW+1:2] : idx_q;
        wen_nx   = accept ? bus.wen : wen_q;
        rdata_nx = '0;
        if (state_nx == RESP && !wen_nx) begin
            rdata_nx = mem[idx_nx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            resp_valid_q <= (state_nx == RESP);
            rdata_q      <= rdata_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= bus.addr[AW+1:2];
            wen_q   <= bus.wen;
            wdata_q <= bus.wdata;
            wmask_q <= bus.wmask;
        end
    end

    // Commit only at the edge closing RESP; a reset before then drops the write.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && wen_q) begin
            for (int i = 0; i < SB_MASK_W; i++) begin
                if (wmask_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.respValid = resp_valid_q;
    assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_ysyx_25070198_simplebus_sram.sv
// Scoreboard bench for the SimpleBus SRAM: three instances (LATENCY 1, 3, 4)
// share one expectation queue; only one instance is busy at any time.
module tb_ysyx_25070198_simplebus_sram;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        int          acc;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        sb[$];

    logic        req_v   [3];
    logic        wen_a   [3];
    logic [31:0] addr_a  [3];
    logic [31:0] wdata_a [3];
    logic [3:0]  mask_a  [3];
    logic        resp_v  [3];
    logic [31:0] rdata_a [3];

    logic [31:0] model [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;

        ysyx_25070198_simplebus_sram_if bus_i ();

        assign bus_i.reqValid = req_v[g];
        assign bus_i.wen      = wen_a[g];
        assign bus_i.addr     = addr_a[g];
        assign bus_i.wdata    = wdata_a[g];
        assign bus_i.wmask    = mask_a[g];
        assign resp_v[g]      = bus_i.respValid;
        assign rdata_a[g]     = bus_i.rdata;

        ysyx_25070198_simplebus_sram #(
            .DEPTH   (1024),
            .LATENCY (L)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus_i)
        );

        always @(negedge clk) begin
            exp_t e;
            int   lat;
            if (!rst) begin
                if (resp_v[g]) begin
                    n_tests++;
                    if (sb.size() == 0 || sb[0].inst != g) begin
                        n_fail++;
                        $display("FAIL unexpected_resp inst%0d: respValid got 1, required 0 (cycle %0d)", g, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (rdata_a[g] !== e.rdata) begin
                            n_fail++;
                            $display("FAIL %s rdata inst%0d: got %h, required %h", e.nm, g, rdata_a[g], e.rdata);
                        end
                        lat = cyc - e.acc + 1;
                        n_tests++;
`ifdef SIMPLEBUS_SRAM_RAND_DELAY_EN
                        if (lat < L || lat > L + 7) begin
                            n_fail++;
                            $display("FAIL %s latency inst%0d: got %0d, required %0d..%0d", e.nm, g, lat, L, L + 7);
                        end
`else
                        if (lat != L) begin
                            n_fail++;
                            $display("FAIL %s latency inst%0d: got %0d, required %0d", e.nm, g, lat, L);
                        end
`endif
                    end
                end else begin
                    n_tests++;
                    if (rdata_a[g] !== 32'h0) begin
                        n_fail++;
                        $display("FAIL rdata_idle inst%0d: got %h, required 00000000 (cycle %0d)", g, rdata_a[g], cyc);
                    end
                end
            end
        end
    end

    task automatic issue(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] m, input logic [31:0] ex, input string nm, input bit push);
        exp_t e;
        @(negedge clk);
        req_v[d]   = 1'b1;
        wen_a[d]   = w;
        addr_a[d]  = a;
        wdata_a[d] = wd;
        mask_a[d]  = m;
        if (push) begin
            e.inst  = d;
            e.rdata = ex;
            e.acc   = cyc + 1;
            e.nm    = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        // Scramble the bus after acceptance; the in-flight request must not notice.
        req_v[d]   = 1'b0;
        wen_a[d]   = ~w;
        addr_a[d]  = $urandom;
        wdata_a[d] = $urandom;
        mask_a[d]  = 4'($urandom);
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: pending responses %0d, required 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic op(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] m, input logic [31:0] ex, input string nm);
        issue(d, w, a, wd, m, ex, nm, 1'b1);
        wait_done(nm);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        if (m[0]) r[7:0]   = nw[7:0];
        if (m[1]) r[15:8]  = nw[15:8];
        if (m[2]) r[23:16] = nw[23:16];
        if (m[3]) r[31:24] = nw[31:24];
        return r;
    endfunction

    initial begin
        logic [31:0] a, wd;
        logic [3:0]  m;
        int          ix;
        bit          w;

        for (int i = 0; i < 3; i++) begin
            req_v[i] = 1'b0; wen_a[i] = 1'b0; addr_a[i] = '0; wdata_a[i] = '0; mask_a[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (resp_v[i] !== 1'b0 || rdata_a[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset inst%0d: respValid/rdata got %b/%h, required 0/00000000", i, resp_v[i], rdata_a[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);

        // LATENCY=1 basic write/read, byte masks, zero mask, address wrap.
        op(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, "w_10");
        op(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, "r_10");
        op(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, "w_20a");
        op(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, "w_20b");
        op(0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, "r_20");
        op(0, 1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h0, "w_30");
        op(0, 1, 32'h30, 32'h00000000, 4'h0, 32'h0, "w_30_nomask");
        op(0, 0, 32'h30, 32'h0, 4'h0, 32'hCAFEF00D, "r_30");
        op(0, 1, 32'h1004, 32'h5A5A5A5A, 4'hF, 32'h0, "w_1004");
        op(0, 0, 32'h0004, 32'h0, 4'h0, 32'h5A5A5A5A, "r_0004");
        op(0, 0, 32'h0007, 32'h0, 4'h0, 32'h5A5A5A5A, "r_0007");

        // LATENCY=4: write requests held on the bus during BUSY/RESP are ignored.
        op(2, 1, 32'h80, 32'h13572468, 4'hF, 32'h0, "w_80");
        issue(2, 0, 32'h80, 32'h0, 4'h0, 32'h13572468, "r_80_busy", 1'b1);
        req_v[2] = 1'b1; wen_a[2] = 1'b1; addr_a[2] = 32'h80; wdata_a[2] = 32'hBAD0BAD0; mask_a[2] = 4'hF;
        repeat (4) @(negedge clk);
        req_v[2] = 1'b0;
        wait_done("r_80_busy");
        op(2, 0, 32'h80, 32'h0, 4'h0, 32'h13572468, "r_80_after");

        // LATENCY=3: reset one cycle after accepting a write abandons it.
        op(1, 1, 32'h40, 32'h12345678, 4'hF, 32'h0, "w_40");
        issue(1, 1, 32'h40, 32'hFFFFFFFF, 4'hF, 32'h0, "w_40_abort", 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        op(1, 0, 32'h40, 32'h0, 4'h0, 32'h12345678, "r_40_after_rst");

        // Random traffic on 16 words of the LATENCY=1 instance, upper bits wrap.
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            op(0, 1, 32'(i) << 2, model[i], 4'hF, 32'h0, "rnd_init");
        end
        for (int i = 0; i < 200; i++) begin
            ix = $urandom_range(0, 15);
            a  = ($urandom & 32'hFFFF_F000) | (32'(ix) << 2) | 32'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            m  = 4'($urandom_range(0, 15));
            if (w) begin
                op(0, 1, a, wd, m, 32'h0, "rnd_w");
                model[ix] = merge(model[ix], wd, m);
            end else begin
                op(0, 0, a, wd, m, model[ix], "rnd_r");
            end
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

endmodule
